// File: rtl/mdu_if.sv
// mdu_if: request/result bus between pipeline control (master) and the multiply/divide unit (slave).
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, sign, a, b, flush, input busy, done, hi, lo);
  modport slave (input start, op, sign, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: 32-iteration shift-add multiply / restoring divide sequencer owning HI/LO, plus MTHI/MTLO.
module mdu_ctrl #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd, hi_r, lo_r;
  logic               is_div, neg_a, neg_b, dz, done_r, accept, ge;
  logic [WIDTH-1:0]   abs_a, abs_b, dsub, q_s, r_s;
  logic [WIDTH:0]     msum, dshift;
  logic [2*WIDTH-1:0] prod, prod_s;
  assign accept = bus.start && !bus.flush && state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (bus.flush) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = (bus.start && !bus.op[1]) ? CALC : IDLE;
    else if (state == CALC) state_nxt = (cnt == 5'd31) ? FIX : CALC;
    else state_nxt = IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = done_r;
    bus.hi   = hi_r;
    bus.lo   = lo_r;
  end
  always_comb begin
    abs_a  = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b  = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    msum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    dshift = {acc_hi, acc_lo[WIDTH-1]};
    ge     = dshift >= {1'b0, opnd};
    dsub   = dshift[WIDTH-1:0] - opnd;
    prod   = {acc_hi, acc_lo};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    q_s    = dz ? {WIDTH{1'b1}} : (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    r_s    = neg_a ? -acc_hi : acc_hi;
  end
  // Divide by zero needs no special loop: a zero divisor leaves |a| in the remainder and all ones in the quotient.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept && bus.op[1]) begin
        if (bus.op[0]) lo_r <= bus.a;
        else hi_r <= bus.a;
        done_r <= 1'b1;
      end
      if (accept && !bus.op[1]) begin
        is_div <= bus.op[0];
        neg_a  <= bus.sign && bus.a[WIDTH-1];
        neg_b  <= bus.sign && bus.b[WIDTH-1];
        dz     <= bus.op[0] && bus.b == '0;
        opnd   <= bus.op[0] ? abs_b : abs_a;
        acc_lo <= bus.op[0] ? abs_a : abs_b;
        acc_hi <= '0;
        cnt    <= '0;
      end
      if (state == CALC) begin
        cnt    <= cnt + 5'd1;
        acc_hi <= is_div ? (ge ? dsub : dshift[WIDTH-1:0]) : msum[WIDTH:1];
        acc_lo <= is_div ? {acc_lo[WIDTH-2:0], ge} : {msum[0], acc_lo[WIDTH-1:1]};
      end
      if (state == FIX && !bus.flush) begin
        hi_r   <= is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
        lo_r   <= is_div ? q_s : prod_s[WIDTH-1:0];
        done_r <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized scoreboard bench for mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  mdu_if #(.WIDTH(32)) bus();
  mdu_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", bus.hi, bus.lo);
      end else check("result", {bus.hi, bus.lo}, exp_q.pop_front());
    end

  function automatic logic [63:0] model(input logic [1:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 2'b10) return {a, m_lo};
    if (op == 2'b11) return {m_hi, a};
    if (op == 2'b00) begin
      if (sg) return sa * sb;
      return ua * ub;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = model(op, sg, a, b);
    {m_hi, m_lo} = e;
    exp_q.push_back(e);
    bus.op = op;
    bus.sign = sg;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    if (op[1]) check("mt_busy", 64'(bus.busy), 64'd0);
    else begin
      n = 0;
      while (bus.busy && n < 100) begin
        n++;
        if (n == 5) begin
          bus.start = 1'b1;
          bus.op = 2'($urandom);
          bus.a = $urandom;
          bus.b = $urandom;
        end
        if (n == 6) bus.start = 1'b0;
        @(negedge clk);
      end
      check("busy_len", 64'(n), 64'd33);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 2'b00;
    bus.sign = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #3 check("reset_state", {bus.hi, bus.lo}, 64'd0);
    check("reset_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7);
    issue(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(2'b01, 1'b0, 32'd7, 32'd2);
    issue(2'b01, 1'b1, 32'd7, 32'hFFFF_FFFE);
    issue(2'b01, 1'b0, 32'h1234_5678, 32'd0);
    issue(2'b01, 1'b1, 32'h8765_4321, 32'd0);
    issue(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 1'b0, 32'hA5A5_A5A5, 32'd0);
    issue(2'b10, 1'b0, 32'h5A5A_5A5A, 32'd0);
    issue(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000);
    bus.op = 2'b00;
    bus.sign = 1'b1;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    for (int k = 0; k < 4; k++) begin
      bus.op = 2'(k);
      bus.a = $urandom;
      bus.b = $urandom;
      bus.flush = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check("flush_start_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
      check("flush_start_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    end
    for (int k = 0; k < 40; k++)
      issue(2'($urandom), 1'($urandom), pick(), pick());
    bus.op = 2'b01;
    bus.sign = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    issue(2'b10, 1'b0, 32'h0BAD_F00D, 32'd0);
    issue(2'b01, 1'b0, 32'hDEAD_BEEF, 32'd3);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
